// File: rtl/fifo_rr_ctrl_pkg.sv
// Shared helpers for the round-robin FIFO front-end: grant index width and
// modulo increment for the rotating priority pointer.
package fifo_ctrl_pkg;

  function automatic int gid_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_REQ_DEF = 4;
  localparam int GID_W_DEF   = gid_w(NUM_REQ_DEF);

  // Explicit wrap so non-power-of-two requester counts never index past n-1.
  function automatic int rr_next(int idx, int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_ctrl_if.sv
// Producer/consumer handshake bundle of the FIFO front-end.
interface fifo_rr_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_BW = 4
);
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_BW-1:0] req_data;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_BW-1:0]         out_data;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data
  );
endinterface

// File: rtl/fifo_rr_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request scanning upward from rr_ptr.
module rr_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int GID_W   = gid_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GID_W-1:0]   grant_id
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grant_id = GID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/fifo_rr_ctrl.sv
// Round-robin write arbitration and pointer/count control for the fifo_reg storage.
// Optional high-water-mark tracking is enabled with `define FIFO_HWM_EN.
module fifo_rr_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter  int ADDR_BW = 1,
  parameter  int DATA_BW = 4,
  parameter  int NUM_REQ = 4,
  localparam int GID_W   = gid_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  fifo_rr_ctrl_if.slave      bus,
  output logic               st_push,
  output logic [ADDR_BW-1:0] st_next_wrptr,
  output logic [ADDR_BW-1:0] st_next_rdptr,
  output logic [ADDR_BW:0]   st_next_numitem,
  output logic [DATA_BW-1:0] st_din,
  input  logic [ADDR_BW-1:0] st_wrptr,
  input  logic [ADDR_BW-1:0] st_rdptr,
  input  logic [ADDR_BW:0]   st_numitem,
  input  logic [DATA_BW-1:0] st_dout,
  output logic [GID_W-1:0]   grant_id
`ifdef FIFO_HWM_EN
  ,
  input  logic               hwm_clr,
  output logic [ADDR_BW:0]   hwm
`endif
);

  localparam logic [ADDR_BW:0] DEPTH = (ADDR_BW + 1)'(2 ** ADDR_BW);

  logic [GID_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] grant;
  logic [GID_W-1:0]   win_id;
  logic               full, empty, pop, push, any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (bus.req_valid),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_id (win_id)
  );

  assign full     = (st_numitem == DEPTH);
  assign empty    = (st_numitem == '0);
  assign any_req  = |bus.req_valid;

  assign bus.out_valid = !empty;
  assign bus.out_data  = st_dout;
  assign pop           = !empty & bus.out_ready & !flush;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push          = any_req & (!full | pop) & !flush;

  assign bus.req_ready = {NUM_REQ{push}} & grant;
  assign st_push       = push;
  assign grant_id      = win_id;

  always_comb begin
    st_din = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) st_din = bus.req_data[i*DATA_BW +: DATA_BW];
    end
  end

  assign st_next_wrptr   = flush ? '0 : st_wrptr + ADDR_BW'(push);
  assign st_next_rdptr   = flush ? '0 : st_rdptr + ADDR_BW'(pop);
  assign st_next_numitem = flush ? '0
                         : st_numitem + (ADDR_BW + 1)'(push) - (ADDR_BW + 1)'(pop);

  always_ff @(posedge clk) begin
    if (rst)       rr_ptr <= '0;
    else if (push) rr_ptr <= GID_W'(rr_next(int'(win_id), NUM_REQ));
  end

`ifdef FIFO_HWM_EN
  // Clear has priority over capturing a new maximum; flush leaves the mark alone.
  always_ff @(posedge clk) begin
    if (rst || hwm_clr)             hwm <= '0;
    else if (st_next_numitem > hwm) hwm <= st_next_numitem;
  end
`endif

endmodule
